ps2_key_sequencer: RTL
======================

# ps2_key_sequencer

Frame receiver and scan-code sequencer for the PS/2 keyboard path, clocked directly by `ps2_clk`. It does four things:
- Samples 11-bit PS/2 frames and checks start, odd parity and stop bits.
- Folds the E0/F0 prefix bytes and the 8-byte Pause sequence into single key events.
- Pushes each event into the downstream key queue, which is also clocked by `ps2_clk`.
- Counts events dropped because the queue is full.

It sits between the PS/2 pins and the key queue, and is the only writer of that queue.

## Interface
- `DROP_W`, default 8: width of the dropped-event counter.
- `PAUSE_SKIP`, default 7: number of bytes swallowed after the E1 Pause lead-in byte.

Ports:
- `ps2_clk` in 1: PS/2 clock. Everything is sampled on `posedge ps2_clk`.
- `rst_n` in 1: reset, synchronous, active-low. Clock is `ps2_clk`.
- `ps2_data` in 1: PS/2 data line.
- `q_full` in 1: key queue full flag, in the `ps2_clk` domain.
- `evt_we` out 1: key-queue write strobe.
- `evt_code` out 8: scan code of the event.
- `evt_ext` out 1: extended key; the event was E0-prefixed, or is Pause.
- `evt_brk` out 1: release event; the event was F0-prefixed.
- `frame_err` out 1: sticky. Set by a bad parity or stop bit.
- `drop_cnt` out `DROP_W`: saturating count of events dropped because of `q_full`.

## Operation
Frame receiver:
- Bit counter `bcnt` runs 0..10 and advances once per `ps2_clk` edge.
- At `bcnt`=0 (start bit): if `ps2_data`=1, the edge is a glitch. `bcnt` stays 0 and nothing is stored.
- `bcnt`=1..8: shift D0..D7 into the byte register, LSB first.
- `bcnt`=9: capture the parity bit.
- `bcnt`=10: stop bit. The frame is good when XOR(D7..D0, parity)=1 and stop=1. `bcnt` returns to 0.
- Bad frame: set `frame_err`, discard the byte, force the sequencer to S_IDLE. No event is produced.

Sequencer, evaluated on each good byte B:
- S_IDLE:
  - B=E0 → S_E0.
  - B=F0 → S_F0.
  - B=E1 → S_PAUSE, load `skip`=`PAUSE_SKIP`.
  - B ∈ {AA, FA, EE, FE, 00, FF} (status bytes) → ignored, stay in S_IDLE.
  - Any other B → emit (B, ext=0, brk=0).
- S_E0:
  - B=F0 → S_E0F0.
  - B=E0 → stay in S_E0.
  - Otherwise → emit (B, 1, 0), go to S_IDLE.
- S_F0: emit (B, 0, 1), go to S_IDLE.
- S_E0F0: emit (B, 1, 1), go to S_IDLE.
- S_PAUSE: decrement `skip` on each good byte. When `skip` reaches 0, emit (E1, 1, 0) and go to S_IDLE.
- A bad frame in any state aborts the sequence and returns to S_IDLE.

Emit:
- If `q_full`=0 at the stop-bit edge: register `evt_we`=1 with code/ext/brk.
- Otherwise: `evt_we`=0, and `drop_cnt` increments, saturating at 2^`DROP_W`−1.

## Timing
- Reset applies only on a `ps2_clk` edge while `rst_n`=0. Reset values:
  - `bcnt`=0, state S_IDLE, `skip`=0.
  - `evt_we`=0, `evt_code`=0, `evt_ext`=0, `evt_brk`=0.
  - `frame_err`=0, `drop_cnt`=0.
- Reset mid-frame discards the partial byte and any pending prefix.
- Event latency: `evt_we`, `evt_code`, `evt_ext` and `evt_brk` are registered at the stop-bit edge (edge 11 of the frame).
- `evt_we` is high for exactly one `ps2_clk` period. It clears on the next edge, which is the next frame's start bit, and the queue commits on that edge.
- `evt_code`, `evt_ext` and `evt_brk` hold their value until the next emit.
- `q_full` is sampled only at the stop-bit edge.
- `evt_we` is 0 on every edge other than the edge following an emit.
- `frame_err` and `drop_cnt` change only at stop-bit edges. Only reset clears them.
- `drop_cnt` at max stays at max. Nothing wraps.
- A glitch start bit (`ps2_data`=1 at `bcnt`=0) consumes the edge. It does not clear a pending `evt_we`; `evt_we` still clears on that edge as normal.

## Test plan
- Frame 0x1C (parity 0, stop 1), `q_full`=0 → `evt_we`=1 for one period with code 1C, ext 0, brk 0.
- Frames E0, F0, 75 → exactly one event, code 75, ext 1, brk 1. No events for the prefix bytes.
- Frame 0x1C with parity 1 → `frame_err`=1, no event. The following frame 0x1C with correct parity → event 1C.
- F0 frame, then 0x1C frame with `q_full`=1 → no `evt_we`, `drop_cnt`=1. Repeat 300 times with `DROP_W`=8 → `drop_cnt`=255.
- Sequence E1 14 77 E1 F0 14 F0 77 → exactly one event (E1, ext 1, brk 0) after the last byte.
- `rst_n`=0 for one edge after 5 bits of a frame, then frame 0x29 → single event 29, no `frame_err`. A leading `ps2_data`=1 edge before the start bit is ignored.

Source files
------------

// File: rtl/ps2_key_sequencer_if.sv
// ----------------------------------------------------------------------------
// ps2_key_sequencer_if
// Write-side bundle between the PS/2 key sequencer and the downstream key
// queue. Everything here is in the ps2_clk domain.
//   q_full   : queue full flag, driven by the queue
//   evt_we   : one-period write strobe for a key event
//   evt_code : scan code of the event
//   evt_ext  : extended key (E0-prefixed, or Pause)
//   evt_brk  : release event (F0-prefixed)
// master = sequencer (the only writer of the queue), slave = key queue.
// ----------------------------------------------------------------------------
interface ps2_key_sequencer_if;
    logic       q_full;
    logic       evt_we;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_brk;

    modport master (
        input  q_full,
        output evt_we, evt_code, evt_ext, evt_brk
    );

    modport slave (
        output q_full,
        input  evt_we, evt_code, evt_ext, evt_brk
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// ----------------------------------------------------------------------------
// ps2_key_sequencer
// Receives 11-bit PS/2 frames directly on ps2_clk, checks them, folds the
// E0/F0 prefixes and the Pause (E1 ...) sequence into single key events and
// writes those events into the key queue.
//   ps2_clk   : PS/2 clock, everything is sampled on its rising edge
//   rst_n     : synchronous active-low reset
//   ps2_data  : PS/2 data line
//   kq        : key queue write port (q_full in, evt_* out)
//   frame_err : sticky, set by a bad parity or stop bit
//   drop_cnt  : saturating count of events lost because the queue was full
// ----------------------------------------------------------------------------
module ps2_key_sequencer #(
    parameter int DROP_W     = 8,
    parameter int PAUSE_SKIP = 7
) (
    input  logic                   ps2_clk,
    input  logic                   rst_n,
    input  logic                   ps2_data,
    ps2_key_sequencer_if.master    kq,
    output logic                   frame_err,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int SKIP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_PAUSE
    } seq_state_t;

    logic [3:0]        bcnt;
    logic [7:0]        shreg;
    logic              par_bit;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [SKIP_W-1:0] skip;
    logic [SKIP_W-1:0] skip_nxt;

    logic              stop_edge;
    logic              frame_good;
    logic              emit;
    logic [7:0]        emit_code;
    logic              emit_ext;
    logic              emit_brk;

    // Keyboard status/acknowledge bytes that never represent a key.
    function automatic logic is_status(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // The stop-bit edge is the only edge on which a byte is judged; at that
    // edge ps2_data itself is the stop bit.
    assign stop_edge  = (bcnt == 4'd10);
    assign frame_good = (^{shreg, par_bit}) & ps2_data;

    // Frame receiver: bit counter plus LSB-first shift register. A high
    // level at the start-bit position is treated as a glitch and the edge is
    // simply consumed without leaving bcnt 0.
    always_ff @(posedge ps2_clk) begin
        if (!rst_n) begin
            bcnt    <= 4'd0;
            shreg   <= 8'h00;
            par_bit <= 1'b0;
        end else begin
            case (bcnt)
                4'd0: begin
                    if (!ps2_data) begin
                        bcnt <= 4'd1;
                    end
                end
                4'd9: begin
                    par_bit <= ps2_data;
                    bcnt    <= 4'd10;
                end
                4'd10: begin
                    bcnt <= 4'd0;
                end
                default: begin
                    shreg <= {ps2_data, shreg[7:1]};
                    bcnt  <= bcnt + 4'd1;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge ps2_clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            skip  <= '0;
        end else begin
            state <= state_nxt;
            skip  <= skip_nxt;
        end
    end

    // Sequencer next-state and emit decision. Only acts at the stop-bit edge;
    // a bad frame aborts whatever prefix or Pause sequence was in progress.
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip;
        emit      = 1'b0;
        emit_code = shreg;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        if (stop_edge) begin
            if (!frame_good) begin
                state_nxt = S_IDLE;
                skip_nxt  = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (shreg == 8'hE0) begin
                            state_nxt = S_E0;
                        end else if (shreg == 8'hF0) begin
                            state_nxt = S_F0;
                        end else if (shreg == 8'hE1) begin
                            state_nxt = S_PAUSE;
                            skip_nxt  = SKIP_W'(PAUSE_SKIP);
                        end else if (!is_status(shreg)) begin
                            emit = 1'b1;
                        end
                    end
                    S_E0: begin
                        if (shreg == 8'hF0) begin
                            state_nxt = S_E0F0;
                        end else if (shreg != 8'hE0) begin
                            emit      = 1'b1;
                            emit_ext  = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                    S_F0: begin
                        emit      = 1'b1;
                        emit_brk  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                    S_E0F0: begin
                        emit      = 1'b1;
                        emit_ext  = 1'b1;
                        emit_brk  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                    S_PAUSE: begin
                        // The whole Pause sequence collapses into one E1 event
                        // once the last swallowed byte arrives.
                        if (skip <= SKIP_W'(1)) begin
                            skip_nxt  = '0;
                            emit      = 1'b1;
                            emit_code = 8'hE1;
                            emit_ext  = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            skip_nxt = skip - SKIP_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = S_IDLE;
                        skip_nxt  = '0;
                    end
                endcase
            end
        end
    end

    // Queue write port and status. evt_we is a single-period strobe that the
    // next edge (the following frame's start bit, or a glitch) always clears.
    // The code/ext/brk registers only move on a real write so the queue sees
    // stable data; a dropped event leaves them untouched.
    always_ff @(posedge ps2_clk) begin
        if (!rst_n) begin
            kq.evt_we   <= 1'b0;
            kq.evt_code <= 8'h00;
            kq.evt_ext  <= 1'b0;
            kq.evt_brk  <= 1'b0;
            frame_err   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            kq.evt_we <= 1'b0;
            if (stop_edge) begin
                if (!frame_good) begin
                    frame_err <= 1'b1;
                end else if (emit) begin
                    if (!kq.q_full) begin
                        kq.evt_we   <= 1'b1;
                        kq.evt_code <= emit_code;
                        kq.evt_ext  <= emit_ext;
                        kq.evt_brk  <= emit_brk;
                    end else if (drop_cnt != {DROP_W{1'b1}}) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
